// File: rtl/axi_mcast_pkg.sv
// Shared types for the multicast B-join path: AXI response codes, the response
// merge rule and the per-ID tracker states.
package axi_mcast_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   typedef enum logic {
      IDLE,
      COLLECT
   } trk_state_t;

   // Errors dominate by severity; EXOKAY survives only if every beat was EXOKAY.
   function automatic resp_t resp_merge(input resp_t a, input resp_t b);
      if (a >= RESP_SLVERR || b >= RESP_SLVERR) begin
         return (a > b) ? a : b;
      end
      return (a == RESP_EXOKAY && b == RESP_EXOKAY) ? RESP_EXOKAY : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_mcast_b_tracker.sv
// Per-ID join tracker: counts the B beats a multicast write still owes and
// folds their responses into one accumulated response.
module axi_mcast_b_tracker
   import axi_mcast_pkg::*;
#(
   parameter int FanoutWidth = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   load_i,
   input  logic [FanoutWidth-1:0] fanout_i,
   input  logic                   beat_i,
   input  resp_t                  resp_i,
   output logic                   busy_o,
   output logic                   is_final_o,
   output resp_t                  merged_resp_o
);

   trk_state_t             state_q, state_d;
   logic [FanoutWidth-1:0] rem_q, rem_d;
   resp_t                  acc_q, acc_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
         acc_q   <= RESP_EXOKAY;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
      end
   end

   // Beats reaching an IDLE tracker are unicast and handled entirely by the top.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (load_i) begin
               state_d = COLLECT;
               rem_d   = fanout_i;
               acc_d   = RESP_EXOKAY;
            end
         end
         COLLECT: begin
            if (beat_i) begin
               if (is_final_o) begin
                  state_d = IDLE;
                  rem_d   = '0;
                  acc_d   = RESP_EXOKAY;
               end else begin
                  rem_d = rem_q - FanoutWidth'(1);
                  acc_d = merged_resp_o;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o        = (state_q == COLLECT);
   assign is_final_o    = busy_o && (rem_q == FanoutWidth'(1));
   assign merged_resp_o = resp_merge(acc_q, resp_i);

endmodule

// File: rtl/axi_mcast_b_joiner.sv
// Multicast write-response joiner: absorbs all but the last B of a multicast
// write and emits one merged B per write. Optional: AXI_MCAST_B_JOINER_STATS_EN.
module axi_mcast_b_joiner
   import axi_mcast_pkg::*;
#(
   parameter  int AxiIdBits   = 2,
   parameter  int MaxFanout   = 4,
   parameter  int FanoutWidth = $clog2(MaxFanout) + 1,
   localparam int NoIds       = 2 ** AxiIdBits
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_valid_i,
   output logic                   push_ready_o,
   input  logic [AxiIdBits-1:0]   push_id_i,
   input  logic [FanoutWidth-1:0] push_fanout_i,
   input  logic                   in_b_valid_i,
   output logic                   in_b_ready_o,
   input  logic [AxiIdBits-1:0]   in_b_id_i,
   input  resp_t                  in_b_resp_i,
   output logic                   out_b_valid_o,
   input  logic                   out_b_ready_i,
   output logic [AxiIdBits-1:0]   out_b_id_o,
   output resp_t                  out_b_resp_o,
   output logic [NoIds-1:0]       busy_o,
   output logic                   merged_pop_o,
   output logic [15:0]            mcast_done_cnt_o
);

   localparam logic [FanoutWidth-1:0] MaxFo = FanoutWidth'(MaxFanout);

   logic [NoIds-1:0]     busy;
   logic [NoIds-1:0]     is_final;
   resp_t                merged [NoIds];
   logic                 push_hs, fanout_legal, mcast_push;
   logic                 slot_free, absorb, in_hs;
   logic                 out_valid_q;
   logic [AxiIdBits-1:0] out_id_q;
   resp_t                out_resp_q;

   assign push_ready_o = ~busy[push_id_i];
   assign push_hs      = push_valid_i && push_ready_o;
   assign fanout_legal = (push_fanout_i != '0) && (push_fanout_i <= MaxFo);
   assign mcast_push   = push_hs && fanout_legal && (push_fanout_i >= FanoutWidth'(2));

   // Non-final multicast beats never touch the output slot, so they bypass backpressure.
   assign slot_free    = !out_valid_q || out_b_ready_i;
   assign absorb       = busy[in_b_id_i] && !is_final[in_b_id_i];
   assign in_b_ready_o = !rst_i && (absorb || slot_free);
   assign in_hs        = in_b_valid_i && in_b_ready_o;

   for (genvar i = 0; i < NoIds; i++) begin : g_trk
      axi_mcast_b_tracker #(
         .FanoutWidth(FanoutWidth)
      ) u_trk (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .load_i       (mcast_push && (push_id_i == AxiIdBits'(i))),
         .fanout_i     (push_fanout_i),
         .beat_i       (in_hs && (in_b_id_i == AxiIdBits'(i))),
         .resp_i       (in_b_resp_i),
         .busy_o       (busy[i]),
         .is_final_o   (is_final[i]),
         .merged_resp_o(merged[i])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_resp_q  <= RESP_OKAY;
      end else if (in_hs && !absorb) begin
         out_valid_q <= 1'b1;
         out_id_q    <= in_b_id_i;
         out_resp_q  <= busy[in_b_id_i] ? merged[in_b_id_i] : in_b_resp_i;
      end else if (out_b_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_b_valid_o = out_valid_q;
   assign out_b_id_o    = out_id_q;
   assign out_b_resp_o  = out_resp_q;
   assign busy_o        = busy;
   assign merged_pop_o  = out_valid_q && out_b_ready_i;

`ifdef AXI_MCAST_B_JOINER_STATS_EN
   logic        out_mcast_q;
   logic [15:0] done_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_mcast_q <= 1'b0;
      end else if (in_hs && !absorb) begin
         out_mcast_q <= busy[in_b_id_i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_cnt_q <= '0;
      end else if (merged_pop_o && out_mcast_q && (done_cnt_q != 16'hFFFF)) begin
         done_cnt_q <= done_cnt_q + 16'd1;
      end
   end

   assign mcast_done_cnt_o = done_cnt_q;
`else
   assign mcast_done_cnt_o = '0;
`endif

   a_push_fanout_legal : assert property (@(posedge clk_i) disable iff (rst_i)
      push_hs |-> fanout_legal);

endmodule

// File: tb/tb_axi_mcast_b_joiner.sv
// Self-checking bench for axi_mcast_b_joiner: directed scenarios plus random
// traffic compared against a per-write reference model of the join.
`timescale 1ns/1ps
module tb_axi_mcast_b_joiner;
   import axi_mcast_pkg::*;

   localparam int NIds  = 4;
   localparam int MaxFo = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        push_valid_i, push_ready_o;
   logic [1:0]  push_id_i;
   logic [2:0]  push_fanout_i;
   logic        in_b_valid_i, in_b_ready_o;
   logic [1:0]  in_b_id_i;
   logic [1:0]  in_b_resp_i;
   logic        out_b_valid_o, out_b_ready_i;
   logic [1:0]  out_b_id_o;
   logic [1:0]  out_b_resp_o;
   logic [3:0]  busy_o;
   logic        merged_pop_o;
   logic [15:0] mcast_done_cnt_o;

   always #5 clk_i = ~clk_i;

   axi_mcast_b_joiner dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .push_valid_i    (push_valid_i),
      .push_ready_o    (push_ready_o),
      .push_id_i       (push_id_i),
      .push_fanout_i   (push_fanout_i),
      .in_b_valid_i    (in_b_valid_i),
      .in_b_ready_o    (in_b_ready_o),
      .in_b_id_i       (in_b_id_i),
      .in_b_resp_i     (in_b_resp_i),
      .out_b_valid_o   (out_b_valid_o),
      .out_b_ready_i   (out_b_ready_i),
      .out_b_id_o      (out_b_id_o),
      .out_b_resp_o    (out_b_resp_o),
      .busy_o          (busy_o),
      .merged_pop_o    (merged_pop_o),
      .mcast_done_cnt_o(mcast_done_cnt_o)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: each open multicast write keeps the list of responses seen.
   int         fan_m [NIds];
   int         got_m [NIds];
   logic [1:0] rx_m  [NIds][MaxFo];
   int         owed  [NIds];
   logic       exp_valid;
   logic [1:0] exp_id;
   logic [1:0] exp_resp;
   logic       exp_mcast;
   int         exp_cnt;
   bit         last_in_hs;
   bit         hold_v;
   int         hold_id;
   logic [1:0] hold_resp;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] joinResp(input int id);
      int worst  = 0;
      bit all_ex = 1'b1;
      for (int k = 0; k < fan_m[id]; k++) begin
         if (int'(rx_m[id][k]) > worst) worst = int'(rx_m[id][k]);
         if (rx_m[id][k] != 2'b01) all_ex = 1'b0;
      end
      if (worst >= 2) return 2'(worst);
      return all_ex ? 2'b01 : 2'b00;
   endfunction

   task automatic clearModel();
      for (int k = 0; k < NIds; k++) begin
         fan_m[k] = 0;
         got_m[k] = 0;
         owed[k]  = 0;
      end
      exp_valid  = 1'b0;
      exp_id     = 2'b00;
      exp_resp   = 2'b00;
      exp_mcast  = 1'b0;
      exp_cnt    = 0;
      last_in_hs = 1'b0;
      hold_v     = 1'b0;
   endtask

   // One clock: drive inputs, check settled outputs, then advance the model at the edge.
   task automatic applyStimulus(input bit rst, input bit pv, input int pid, input int pfan,
                                input bit iv, input int iid, input logic [1:0] iresp,
                                input bit ordy);
      bit         exp_push_rdy, exp_in_rdy, push_hs, in_hs, load, lm;
      logic [1:0] lresp;
      logic [3:0] exp_busy;
      int         cnt_exp;
      rst_i         = rst;
      push_valid_i  = pv;
      push_id_i     = 2'(pid);
      push_fanout_i = 3'(pfan);
      in_b_valid_i  = iv;
      in_b_id_i     = 2'(iid);
      in_b_resp_i   = iresp;
      out_b_ready_i = ordy;
      #2;
      for (int k = 0; k < NIds; k++) exp_busy[k] = (fan_m[k] != 0);
      exp_push_rdy = (fan_m[pid] == 0);
      exp_in_rdy   = !rst && ((fan_m[iid] != 0 && got_m[iid] < fan_m[iid] - 1) ||
                              !exp_valid || ordy);
`ifdef AXI_MCAST_B_JOINER_STATS_EN
      cnt_exp = exp_cnt;
`else
      cnt_exp = 0;
`endif
      checkOutput("out_valid", 32'(out_b_valid_o), 32'(exp_valid));
      if (exp_valid) begin
         checkOutput("out_id", 32'(out_b_id_o), 32'(exp_id));
         checkOutput("out_resp", 32'(out_b_resp_o), 32'(exp_resp));
      end
      checkOutput("busy", 32'(busy_o), 32'(exp_busy));
      checkOutput("push_ready", 32'(push_ready_o), 32'(exp_push_rdy));
      checkOutput("in_ready", 32'(in_b_ready_o), 32'(exp_in_rdy));
      checkOutput("merged_pop", 32'(merged_pop_o), 32'(exp_valid && ordy));
      checkOutput("done_cnt", 32'(mcast_done_cnt_o), 32'(cnt_exp));
      @(posedge clk_i);
      if (rst) begin
         clearModel();
      end else begin
         push_hs = pv && exp_push_rdy;
         in_hs   = iv && exp_in_rdy;
         load    = 1'b0;
         lm      = 1'b0;
         lresp   = 2'b00;
         if (exp_valid && ordy && exp_mcast && exp_cnt < 65535) exp_cnt++;
         if (in_hs) begin
            owed[iid]--;
            if (fan_m[iid] != 0) begin
               rx_m[iid][got_m[iid]] = iresp;
               got_m[iid]++;
               if (got_m[iid] == fan_m[iid]) begin
                  load       = 1'b1;
                  lresp      = joinResp(iid);
                  lm         = 1'b1;
                  fan_m[iid] = 0;
               end
            end else begin
               load  = 1'b1;
               lresp = iresp;
            end
         end
         if (push_hs) begin
            owed[pid] += pfan;
            if (pfan >= 2) begin
               fan_m[pid] = pfan;
               got_m[pid] = 0;
            end
         end
         if (load) begin
            exp_valid = 1'b1;
            exp_id    = 2'(iid);
            exp_resp  = lresp;
            exp_mcast = lm;
         end else if (ordy) begin
            exp_valid = 1'b0;
         end
         last_in_hs = in_hs;
      end
      #1;
   endtask

   task automatic randomCycle();
      int pid, pfan;
      bit pv, ordy;
      pid  = $urandom_range(0, NIds - 1);
      pv   = 1'b0;
      pfan = 1;
      if ($urandom_range(0, 2) == 0 && (owed[pid] == 0 || fan_m[pid] != 0)) begin
         pv   = 1'b1;
         pfan = $urandom_range(1, MaxFo);
      end
      if (!hold_v && $urandom_range(0, 9) < 6) begin
         int start;
         start = $urandom_range(0, NIds - 1);
         for (int k = 0; k < NIds; k++) begin
            int c;
            c = (start + k) % NIds;
            if (owed[c] > 0 && !hold_v) begin
               hold_v    = 1'b1;
               hold_id   = c;
               hold_resp = 2'($urandom_range(0, 3));
            end
         end
      end
      ordy = ($urandom_range(0, 9) < 7);
      applyStimulus(1'b0, pv, pid, pfan, hold_v, hold_id, hold_resp, ordy);
      if (last_in_hs) hold_v = 1'b0;
   endtask

   initial begin
      clearModel();
      rst_i = 1'b1; push_valid_i = 1'b0; push_id_i = '0; push_fanout_i = 3'd1;
      in_b_valid_i = 1'b0; in_b_id_i = '0; in_b_resp_i = '0; out_b_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      applyStimulus(1, 0, 0, 1, 0, 0, RESP_OKAY, 0);

      // Unicast pass-through
      applyStimulus(0, 1, 1, 1, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 1, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);

      // Triple multicast with SLVERR; same-ID push held off until busy falls
      applyStimulus(0, 1, 2, 3, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 1, 2, 2, 1, 2, RESP_OKAY, 1);
      applyStimulus(0, 1, 2, 2, 1, 2, RESP_SLVERR, 1);
      applyStimulus(0, 1, 2, 2, 1, 2, RESP_OKAY, 1);
      applyStimulus(0, 1, 2, 2, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 2, RESP_EXOKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 2, RESP_EXOKAY, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);

      // EXOKAY merge on id 0, then EXOKAY+OKAY
      applyStimulus(0, 1, 0, 2, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_EXOKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_EXOKAY, 1);
      applyStimulus(0, 1, 0, 2, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_EXOKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);

      // Backpressure: unicast id 3 parked in the slot, final beat of id 0 waits
      applyStimulus(0, 1, 3, 1, 0, 0, RESP_OKAY, 0);
      applyStimulus(0, 1, 0, 2, 0, 0, RESP_OKAY, 0);
      applyStimulus(0, 0, 0, 1, 1, 3, RESP_OKAY, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_DECERR, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_OKAY, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_OKAY, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);

      // Reset with id 1 at rem 2 and the slot full
      applyStimulus(0, 1, 1, 3, 0, 0, RESP_OKAY, 0);
      applyStimulus(0, 1, 3, 1, 1, 1, RESP_OKAY, 0);
      applyStimulus(0, 0, 0, 1, 1, 3, RESP_SLVERR, 0);
      applyStimulus(1, 0, 0, 1, 0, 0, RESP_OKAY, 0);
      applyStimulus(0, 1, 1, 1, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 1, 1, RESP_DECERR, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);
      applyStimulus(0, 0, 0, 1, 0, 0, RESP_OKAY, 1);

      for (int n = 0; n < 3000; n++) randomCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
